// File: rtl/stream_mux_arbiter.sv
// Two-to-one packet multiplexer with a registered output slot; the grant is held until the packet's LAST beat is accepted.
// Optional feature: define STREAM_MUX_RR_EN for a round-robin tie-break in S_IDLE (fixed priority to A otherwise).
// state    | meaning
// S_IDLE   | no packet in progress, arbitrate between A and B
// S_LOCK_A | mid-packet from A, only A may be accepted
// S_LOCK_B | mid-packet from B, only B may be accepted
`timescale 1ns/1ps
module stream_mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a_data,
    input  logic             i_a_last,
    input  logic             i_a_valid,
    output logic             o_a_ready,
    input  logic [WIDTH-1:0] i_b_data,
    input  logic             i_b_last,
    input  logic             i_b_valid,
    output logic             o_b_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    output logic             o_out_sel,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    typedef enum logic [1:0] {S_IDLE, S_LOCK_A, S_LOCK_B} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_sel;
    logic             r_out_valid;
    logic             w_ld_ok;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_acc_a;
    logic             w_acc_b;
    logic             w_tie_b;

    assign w_ld_ok = ~r_out_valid | i_out_ready;
    assign w_acc_a = o_a_ready & i_a_valid;
    assign w_acc_b = o_b_ready & i_b_valid;

`ifdef STREAM_MUX_RR_EN
    // Source of the most recent first beat; the other source wins the next tie.
    logic r_last_gnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_gnt <= 1'b1;
        end else if ((r_state == S_IDLE) && (w_acc_a || w_acc_b)) begin
            r_last_gnt <= w_acc_b;
        end
    end

    assign w_tie_b = ~r_last_gnt;
`else
    assign w_tie_b = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc_a && !i_a_last) begin
                    w_state_nxt = S_LOCK_A;
                end else if (w_acc_b && !i_b_last) begin
                    w_state_nxt = S_LOCK_B;
                end
            end
            S_LOCK_A: if (w_acc_a && i_a_last) w_state_nxt = S_IDLE;
            S_LOCK_B: if (w_acc_b && i_b_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // A locked source keeps the grant even while its VALID is low (bubbles).
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_a_valid && i_b_valid) begin
                    w_gnt_a = ~w_tie_b;
                    w_gnt_b = w_tie_b;
                end else begin
                    w_gnt_a = i_a_valid;
                    w_gnt_b = i_b_valid;
                end
            end
            S_LOCK_A: w_gnt_a = 1'b1;
            S_LOCK_B: w_gnt_b = 1'b1;
            default: begin
                w_gnt_a = 1'b0;
                w_gnt_b = 1'b0;
            end
        endcase
    end

    assign o_a_ready = w_gnt_a & w_ld_ok & ~i_rst;
    assign o_b_ready = w_gnt_b & w_ld_ok & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_acc_a) begin
            r_out_data  <= i_a_data;
            r_out_last  <= i_a_last;
            r_out_sel   <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_acc_b) begin
            r_out_data  <= i_b_data;
            r_out_last  <= i_b_last;
            r_out_sel   <= 1'b1;
            r_out_valid <= 1'b1;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_out_sel   = r_out_sel;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Directed self-checking bench for stream_mux_arbiter; expectations follow STREAM_MUX_RR_EN when defined.
`timescale 1ns/1ps
module tb_stream_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data, out_data;
    logic       a_last, a_valid, a_ready;
    logic       b_last, b_valid, b_ready;
    logic       out_last, out_sel, out_valid, out_ready;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    stream_mux_arbiter #(.WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_a_data   (a_data),
        .i_a_last   (a_last),
        .i_a_valid  (a_valid),
        .o_a_ready  (a_ready),
        .i_b_data   (b_data),
        .i_b_last   (b_last),
        .i_b_valid  (b_valid),
        .o_b_ready  (b_ready),
        .o_out_data (out_data),
        .o_out_last (out_last),
        .o_out_sel  (out_sel),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic s);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
        chk({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
        chk({tag, "_sel"},   {31'd0, out_sel},   {31'd0, s});
    endtask

    task automatic chk_rdy(input string tag, input logic ra, input logic rb);
        #1;
        chk({tag, "_a_ready"}, {31'd0, a_ready}, {31'd0, ra});
        chk({tag, "_b_ready"}, {31'd0, b_ready}, {31'd0, rb});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       exp_sel;
        logic [7:0] exp_d;

        // reset held with both sources valid
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
        b_valid = 1'b1; b_data = 8'h21; b_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
            chk_rdy("rst", 1'b0, 1'b0);
        end

        // lock: A 3-beat packet while B waits with a single beat
        rst = 1'b0;
        chk_rdy("lock0", 1'b1, 1'b0);
        step();
        chk_out("lock_b1", 1'b1, 8'h11, 1'b0, 1'b0);
        a_data = 8'h12;
        chk_rdy("lock1", 1'b1, 1'b0);
        step();
        chk_out("lock_b2", 1'b1, 8'h12, 1'b0, 1'b0);
        a_data = 8'h13; a_last = 1'b1;
        chk_rdy("lock2", 1'b1, 1'b0);
        step();
        chk_out("lock_b3", 1'b1, 8'h13, 1'b1, 1'b0);
        a_valid = 1'b0;
        chk_rdy("lock3", 1'b0, 1'b1);
        step();
        chk_out("lock_b", 1'b1, 8'h21, 1'b1, 1'b1);
        b_valid = 1'b0;
        step();
        chk_out("lock_drain", 1'b0, 8'h21, 1'b1, 1'b1);

        // tie-break with continuous single-beat packets on both sources
        a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef STREAM_MUX_RR_EN
            exp_sel = i[0];
`else
            exp_sel = 1'b0;
`endif
            exp_d = exp_sel ? 8'hB1 : 8'hA1;
            chk_out("tie", 1'b1, exp_d, 1'b1, exp_sel);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        chk_out("tie_drain", 1'b0, exp_d, 1'b1, exp_sel);

        // backpressure mid-packet
        a_valid = 1'b1; a_data = 8'h31; a_last = 1'b0;
        step();
        chk_out("bp_b1", 1'b1, 8'h31, 1'b0, 1'b0);
        out_ready = 1'b0; a_data = 8'h32;
        for (int i = 0; i < 4; i++) begin
            chk_rdy("bp_hold", 1'b0, 1'b0);
            step();
            chk_out("bp_hold", 1'b1, 8'h31, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        chk_rdy("bp_resume", 1'b1, 1'b0);
        step();
        chk_out("bp_b2", 1'b1, 8'h32, 1'b0, 1'b0);
        a_data = 8'h33; a_last = 1'b1;
        step();
        chk_out("bp_b3", 1'b1, 8'h33, 1'b1, 1'b0);
        a_valid = 1'b0;
        step();
        chk_out("bp_drain", 1'b0, 8'h33, 1'b1, 1'b0);

        // bubble: A drops VALID mid-packet while B is waiting
        a_valid = 1'b1; a_data = 8'h41; a_last = 1'b0;
        chk_rdy("bub0", 1'b1, 1'b0);
        step();
        chk_out("bub_b1", 1'b1, 8'h41, 1'b0, 1'b0);
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'h51; b_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk_rdy("bub_gap", 1'b1, 1'b0);
            step();
            chk_out("bub_gap", 1'b0, 8'h41, 1'b0, 1'b0);
        end
        a_valid = 1'b1; a_data = 8'h42;
        step();
        chk_out("bub_b2", 1'b1, 8'h42, 1'b0, 1'b0);
        a_data = 8'h43; a_last = 1'b1;
        chk_rdy("bub2", 1'b1, 1'b0);
        step();
        chk_out("bub_b3", 1'b1, 8'h43, 1'b1, 1'b0);
        a_valid = 1'b0;
        chk_rdy("bub3", 1'b0, 1'b1);
        step();
        chk_out("bub_b", 1'b1, 8'h51, 1'b1, 1'b1);
        b_valid = 1'b0;
        step();
        chk_out("bub_drain", 1'b0, 8'h51, 1'b1, 1'b1);

        // reset in the middle of an A packet
        a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
        step();
        chk_out("mrst_b1", 1'b1, 8'h61, 1'b0, 1'b0);
        rst = 1'b1; a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'h55; b_last = 1'b1;
        chk_rdy("mrst_hold", 1'b0, 1'b0);
        step();
        chk_out("mrst", 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk_rdy("mrst_rel", 1'b0, 1'b1);
        step();
        chk_out("mrst_b", 1'b1, 8'h55, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
